ram_memory_be: RTL and testbench

RAM_MEMORY_BE -- requirements
Module: ram_memory_be

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_be_core.sv | 38 +++
 rtl/ram_memory_be.sv | 142 ++++++++++++++
 tb/tb_ram_memory_be.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enabled RAM block.
//   ram_state_e : sequencer state (INIT clears memory, READY serves users)
//   RDW_OLD/NEW : read-during-write mode selectors
package ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_be_core.sv
// Byte-enabled simple dual-port storage array.
//   clk_i   : write clock (rising edge)
//   we_i    : write strobe
//   waddr_i : write address
//   be_i    : per-lane write enables
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : combinational read data (pre-write contents on a same-edge write)
// No reset on the array so it can map onto RAM blocks.
module ram_be_core #(
  parameter int DWIDTH = 32,
  parameter int BWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [AWIDTH-1:0]          waddr_i,
  input  logic [DWIDTH/BWIDTH-1:0]   be_i,
  input  logic [DWIDTH-1:0]          wdata_i,
  input  logic [AWIDTH-1:0]          raddr_i,
  output logic [DWIDTH-1:0]          rdata_o
);

  localparam int NBYTES = DWIDTH / BWIDTH;
  localparam int DEPTH  = 2 ** AWIDTH;

  // One independent array per byte lane; lane enables gate each write.
  for (genvar g = 0; g < NBYTES; g++) begin : g_lane
    logic [BWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
      if (we_i && be_i[g]) mem[waddr_i] <= wdata_i[g*BWIDTH +: BWIDTH];
    end

    assign rdata_o[g*BWIDTH +: BWIDTH] = mem[raddr_i];
  end

endmodule

// File: rtl/ram_memory_be.sv
// Byte-enabled RAM with post-reset / on-demand zero-clear sequencer.
//   clk_i, rst_n_i         : clock, async active-low reset
//   init_i                 : request a re-clear (honoured only when ready)
//   wren_i/wrpntr_i/be_i/data_i : byte-enabled write port
//   rden_i/rdpntr_i        : read request
//   q_o/q_valid_o          : registered read data and its one-cycle strobe
//   ready_o                : block accepts reads and writes
module ram_memory_be
  import ram_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int BWIDTH     = 8,
  parameter int AWIDTH     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_NEW    = 1,
  parameter int INIT_EN    = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       init_i,
  input  logic                       wren_i,
  input  logic [AWIDTH-1:0]          wrpntr_i,
  input  logic [DWIDTH/BWIDTH-1:0]   be_i,
  input  logic [DWIDTH-1:0]          data_i,
  input  logic                       rden_i,
  input  logic [AWIDTH-1:0]          rdpntr_i,
  output logic [DWIDTH-1:0]          q_o,
  output logic                       q_valid_o,
  output logic                       ready_o
);

  localparam int NBYTES = DWIDTH / BWIDTH;

  ram_state_e state, state_nxt;
  logic [AWIDTH-1:0] cnt;
  logic              ready_q;

  // ---------------- sequencer ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (cnt == '1) state_nxt = READY;
      READY:   if (init_i)    state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  // ready_q tracks the next state so it equals (state == READY) outside
  // reset, while still reading 0 during reset when INIT_EN=0 boots to READY.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= (INIT_EN != 0) ? INIT : READY;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == READY);
      // Counter wraps to 0 on the last clear and idles at 0 in READY,
      // so every INIT entry starts from address 0.
      if (state == INIT) cnt <= cnt + 1'b1;
      else               cnt <= '0;
    end
  end

  assign ready_o = ready_q;

  // ---------------- write mux ----------------
  logic                wr_acc, rd_acc;
  logic                mem_we;
  logic [AWIDTH-1:0]   mem_waddr;
  logic [NBYTES-1:0]   mem_be;
  logic [DWIDTH-1:0]   mem_wdata;
  logic [DWIDTH-1:0]   mem_rdata;

  assign wr_acc = wren_i & ready_q;
  assign rd_acc = rden_i & ready_q;

  always_comb begin
    mem_we    = wr_acc;
    mem_waddr = wrpntr_i;
    mem_be    = be_i;
    mem_wdata = data_i;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt;
      mem_be    = '1;
      mem_wdata = '0;
    end
  end

  ram_be_core #(
    .DWIDTH (DWIDTH),
    .BWIDTH (BWIDTH),
    .AWIDTH (AWIDTH)
  ) u_core (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .be_i    (mem_be),
    .wdata_i (mem_wdata),
    .raddr_i (rdpntr_i),
    .rdata_o (mem_rdata)
  );

  // ---------------- read-during-write bypass ----------------
  // The array read is pre-write; in new-data mode, enabled lanes of a
  // same-address write are forwarded from data_i.
  logic              rdw_hit;
  logic [DWIDTH-1:0] rd_data;

  assign rdw_hit = (RDW_NEW != RDW_OLD) && wr_acc && (wrpntr_i == rdpntr_i);

  for (genvar g = 0; g < NBYTES; g++) begin : g_byp
    assign rd_data[g*BWIDTH +: BWIDTH] = (rdw_hit && be_i[g]) ?
                                         data_i[g*BWIDTH +: BWIDTH] :
                                         mem_rdata[g*BWIDTH +: BWIDTH];
  end

  // ---------------- read pipeline ----------------
  // Data stages load only alongside a valid bit, so the last stage holds
  // the most recent result between strobes.
  logic [RD_LATENCY-1:0]             vld_pipe;
  logic [RD_LATENCY-1:0][DWIDTH-1:0] dat_pipe;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      if (rd_acc) dat_pipe[0] <= rd_data;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign q_o       = dat_pipe[RD_LATENCY-1];
  assign q_valid_o = vld_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_ram_memory_be.sv
// Directed bench: two instances share one stimulus stream.
//   u1 : RD_LATENCY=1, new-data read-during-write
//   u2 : RD_LATENCY=2, old-data read-during-write
module tb_ram_memory_be;

  logic        clk = 1'b0;
  logic        rst_n, init, wren, rden;
  logic [3:0]  wrpntr, rdpntr, be;
  logic [31:0] data;
  logic [31:0] q1, q2;
  logic        qv1, qv2, rdy1, rdy2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_memory_be #(.DWIDTH(32), .BWIDTH(8), .AWIDTH(4), .RD_LATENCY(1),
                  .RDW_NEW(1), .INIT_EN(1)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .init_i(init), .wren_i(wren),
    .wrpntr_i(wrpntr), .be_i(be), .data_i(data), .rden_i(rden),
    .rdpntr_i(rdpntr), .q_o(q1), .q_valid_o(qv1), .ready_o(rdy1));

  ram_memory_be #(.DWIDTH(32), .BWIDTH(8), .AWIDTH(4), .RD_LATENCY(2),
                  .RDW_NEW(0), .INIT_EN(1)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .init_i(init), .wren_i(wren),
    .wrpntr_i(wrpntr), .be_i(be), .data_i(data), .rden_i(rden),
    .rdpntr_i(rdpntr), .q_o(q2), .q_valid_o(qv2), .ready_o(rdy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    wren = 1'b1; wrpntr = a; data = d; be = b;
    tick();
    wren = 1'b0;
  endtask

  // Read one address; any write set up by the caller shares the same edge.
  task automatic rd(input logic [3:0] a, input logic [31:0] e1,
                    input logic [31:0] e2, input string tag);
    rden = 1'b1; rdpntr = a;
    tick();
    rden = 1'b0; wren = 1'b0;
    chk({tag, "_v1"}, 32'(qv1), 32'd1);
    chk({tag, "_q1"}, q1, e1);
    chk({tag, "_v2early"}, 32'(qv2), 32'd0);
    tick();
    chk({tag, "_v2"}, 32'(qv2), 32'd1);
    chk({tag, "_q2"}, q2, e2);
    chk({tag, "_v1off"}, 32'(qv1), 32'd0);
  endtask

  // Counts edges from now until ready rises; no read strobe may appear.
  task automatic wait_ready(input string tag);
    int   n;
    logic seen;
    n = 0; seen = 1'b0;
    do begin
      tick();
      n++;
      seen |= qv1 | qv2;
    end while (!rdy1 && n < 100);
    chk({tag, "_cycles"}, 32'(n), 32'd16);
    chk({tag, "_rdy2"}, 32'(rdy2), 32'd1);
    chk({tag, "_noqv"}, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b0; wren = 1'b0; rden = 1'b0;
    wrpntr = '0; rdpntr = '0; be = '0; data = '0;
    tick(); tick();
    chk("rst_q1",   q1, 32'h0);
    chk("rst_q2",   q2, 32'h0);
    chk("rst_qv",   32'({qv1, qv2}), 32'h0);
    chk("rst_rdy",  32'({rdy1, rdy2}), 32'h0);

    rst_n = 1'b1;
    wait_ready("boot");
    for (int a = 0; a < 16; a++) rd(4'(a), 32'h0, 32'h0, "boot_clr");

    // byte-lane write over zero
    wr(4'd3, 32'hA5A5_A5A5, 4'b0101);
    rd(4'd3, 32'h00A5_00A5, 32'h00A5_00A5, "be0101");

    // back-to-back reads
    wr(4'd1, 32'h0101_0101, 4'b1111);
    wr(4'd2, 32'h0202_0202, 4'b1111);
    rden = 1'b1; rdpntr = 4'd1;
    tick();
    chk("b2b_e1_v1", 32'(qv1), 32'd1); chk("b2b_e1_q1", q1, 32'h0101_0101);
    chk("b2b_e1_v2", 32'(qv2), 32'd0);
    rdpntr = 4'd2;
    tick();
    chk("b2b_e2_q1", q1, 32'h0202_0202);
    chk("b2b_e2_v2", 32'(qv2), 32'd1); chk("b2b_e2_q2", q2, 32'h0101_0101);
    rdpntr = 4'd3;
    tick();
    chk("b2b_e3_q1", q1, 32'h00A5_00A5);
    chk("b2b_e3_v2", 32'(qv2), 32'd1); chk("b2b_e3_q2", q2, 32'h0202_0202);
    rden = 1'b0;
    tick();
    chk("b2b_e4_v1", 32'(qv1), 32'd0); chk("b2b_hold_q1", q1, 32'h00A5_00A5);
    chk("b2b_e4_v2", 32'(qv2), 32'd1); chk("b2b_e4_q2", q2, 32'h00A5_00A5);
    tick();
    chk("b2b_e5_v2", 32'(qv2), 32'd0); chk("b2b_hold_q2", q2, 32'h00A5_00A5);

    // read-during-write
    wr(4'd5, 32'h1111_1111, 4'b1111);
    wren = 1'b1; wrpntr = 4'd5; data = 32'h2222_2222; be = 4'b1111;
    rd(4'd5, 32'h2222_2222, 32'h1111_1111, "rdw_full");
    wren = 1'b1; wrpntr = 4'd5; data = 32'h3333_3333; be = 4'b0011;
    rd(4'd5, 32'h2222_3333, 32'h2222_2222, "rdw_part");
    wren = 1'b1; wrpntr = 4'd5; data = 32'hFFFF_FFFF; be = 4'b0000;
    rd(4'd5, 32'h2222_3333, 32'h2222_3333, "be_none");
    rd(4'd5, 32'h2222_3333, 32'h2222_3333, "be_none_after");

    // re-clear with a read in flight; writes/reads/init during INIT ignored
    rden = 1'b1; rdpntr = 4'd3;
    tick();
    chk("flt_v1", 32'(qv1), 32'd1); chk("flt_q1", q1, 32'h00A5_00A5);
    rden = 1'b0; init = 1'b1;
    tick();
    chk("flt_v2", 32'(qv2), 32'd1); chk("flt_q2", q2, 32'h00A5_00A5);
    chk("flt_rdy_low", 32'(rdy1), 32'd0);
    wren = 1'b1; wrpntr = 4'd0; data = 32'hFFFF_FFFF; be = 4'b1111;
    rden = 1'b1; rdpntr = 4'd3;
    wait_ready("reinit");
    wren = 1'b0; rden = 1'b0; init = 1'b0;
    for (int a = 0; a < 16; a++) rd(4'(a), 32'h0, 32'h0, "reinit_clr");

    // reset in the middle of clearing
    wr(4'd2, 32'hDEAD_BEEF, 4'b1111);
    rd(4'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "pre_rst");
    init = 1'b1;
    tick();
    init = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_q1", q1, 32'h0);
    chk("midrst_q2", q2, 32'h0);
    chk("midrst_qv", 32'({qv1, qv2}), 32'h0);
    chk("midrst_rdy", 32'({rdy1, rdy2}), 32'h0);
    tick();
    rst_n = 1'b1;
    wait_ready("midrst");
    rd(4'd2, 32'h0, 32'h0, "midrst_clr");
    rd(4'd15, 32'h0, 32'h0, "midrst_clr_top");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
